// File: rtl/register_file_2_read_port.sv
// rtl/register_file_2_read_port.sv - 1-write / 2-read register file with asynchronous reads
module register_file_2_read_port #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_address_i,
   input  logic [DATA_WIDTH-1:0] write_data_i,
   input  logic [ADDR_WIDTH-1:0] read_address_1_i,
   output logic [DATA_WIDTH-1:0] read_data_1_o,
   input  logic [ADDR_WIDTH-1:0] read_address_2_i,
   output logic [DATA_WIDTH-1:0] read_data_2_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Contents are deliberately left uninitialised by reset; occupancy lives in the controller.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (write_en) begin
         mem_q[write_address_i] <= write_data_i;
      end
   end

   assign read_data_1_o = mem_q[read_address_1_i];
   assign read_data_2_o = mem_q[read_address_2_i];

endmodule

// File: rtl/fifo_narrow_to_wide.sv
// rtl/fifo_narrow_to_wide.sv - FIFO taking one narrow word per push, returning two per pop (FWFT)
module fifo_narrow_to_wide #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    wr_i,
   input  logic [DATA_WIDTH-1:0]   w_data_i,
   input  logic                    rd_i,
   output logic [2*DATA_WIDTH-1:0] r_data_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [ADDR_WIDTH:0]     count_o
);

   localparam int DEPTH    = 2 ** ADDR_WIDTH;
   localparam int RD_WIDTH = 2 * DATA_WIDTH;
   localparam int CW       = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  push_ok, pop_ok;
   logic [DATA_WIDTH-1:0] head_lo, head_hi;
   logic [RD_WIDTH-1:0]   head_pair;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q < CW'(2));
   assign count_o = count_q;

   assign push_ok = wr_i & ~full_o;
   assign pop_ok  = rd_i & ~empty_o;

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      if (push_ok) begin
         w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
      end
      // r_ptr stays even, so the head pair never straddles the wrap point.
      if (pop_ok) begin
         r_ptr_d = r_ptr_q + ADDR_WIDTH'(2);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(2);
         2'b11:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
      end
   end

   register_file_2_read_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_regfile (
      .clk_i            (clk_i),
      .write_en         (push_ok),
      .write_address_i  (w_ptr_q),
      .write_data_i     (w_data_i),
      .read_address_1_i (r_ptr_q),
      .read_data_1_o    (head_lo),
      .read_address_2_i (r_ptr_q | ADDR_WIDTH'(1)),
      .read_data_2_o    (head_hi)
   );

   assign head_pair = {head_hi, head_lo};
   assign r_data_o  = head_pair;

endmodule

// File: tb/tb_fifo_narrow_to_wide.sv
// tb/tb_fifo_narrow_to_wide.sv - randomized self-checking bench with a queue reference model
module tb_fifo_narrow_to_wide;

   localparam int AW    = 2;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          wr_i;
   logic [DW-1:0] w_data_i;
   logic          rd_i;
   logic [2*DW-1:0] r_data_o;
   logic          full_o;
   logic          empty_o;
   logic [AW:0]   count_o;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] mq [$];

   always #5 clk_i = ~clk_i;

   fifo_narrow_to_wide #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wr_i     (wr_i),
      .w_data_i (w_data_i),
      .rd_i     (rd_i),
      .r_data_o (r_data_o),
      .full_o   (full_o),
      .empty_o  (empty_o),
      .count_o  (count_o)
   );

   task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
      bit pu, po;
      pu = w && (mq.size() < DEPTH);
      po = r && (mq.size() >= 2);
      wr_i = w; w_data_i = d; rd_i = r;
      @(posedge clk_i); #1;
      if (po) begin
         void'(mq.pop_front());
         void'(mq.pop_front());
      end
      if (pu) mq.push_back(d);
      wr_i = 1'b0; rd_i = 1'b0;
   endtask

   task automatic do_reset(input logic w, input logic r);
      rst_ni = 1'b0; wr_i = w; rd_i = r; w_data_i = 8'hEE;
      @(posedge clk_i); #1;
      rst_ni = 1'b1; wr_i = 1'b0; rd_i = 1'b0;
      mq.delete();
   endtask

   task automatic test_reset;
      do_reset(1'b0, 1'b0);
      checks++;
      if (empty_o !== 1'b1 || full_o !== 1'b0 || count_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_flags got e=%b f=%b c=%0d want e=1 f=0 c=0", empty_o, full_o, count_o);
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (count_o !== 3'd0 || empty_o !== 1'b1) begin
         errors++;
         $display("FAIL pop_when_empty got c=%0d e=%b want c=0 e=1", count_o, empty_o);
      end
   endtask

   task automatic test_basic;
      drive(1'b1, 8'h11, 1'b0);
      checks++;
      if (count_o !== 3'd1 || empty_o !== 1'b1) begin
         errors++;
         $display("FAIL one_word got c=%0d e=%b want c=1 e=1", count_o, empty_o);
      end
      drive(1'b1, 8'h22, 1'b0);
      checks++;
      if (empty_o !== 1'b0 || r_data_o !== 16'h2211) begin
         errors++;
         $display("FAIL first_pair got e=%b d=%h want e=0 d=2211", empty_o, r_data_o);
      end
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (count_o !== 3'd0 || empty_o !== 1'b1) begin
         errors++;
         $display("FAIL pop_pair got c=%0d e=%b want c=0 e=1", count_o, empty_o);
      end
   endtask

   task automatic test_full;
      for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0);
      checks++;
      if (full_o !== 1'b1 || count_o !== 3'd4) begin
         errors++;
         $display("FAIL full got f=%b c=%0d want f=1 c=4", full_o, count_o);
      end
      drive(1'b1, 8'hFF, 1'b1);
      checks++;
      if (count_o !== 3'd2 || full_o !== 1'b0 || r_data_o !== 16'hA3A2) begin
         errors++;
         $display("FAIL push_while_full got c=%0d f=%b d=%h want c=2 f=0 d=a3a2", count_o, full_o, r_data_o);
      end
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (count_o !== 3'd0) begin
         errors++;
         $display("FAIL drain_after_full got c=%0d want 0", count_o);
      end
   endtask

   task automatic test_wrap;
      logic [DW-1:0] n;
      logic [DW-1:0] exp_lo;
      n = 8'h30; exp_lo = 8'h30;
      for (int round = 0; round < 3; round++) begin
         for (int i = 0; i < 4; i++) begin
            drive(1'b1, n, 1'b0);
            n++;
         end
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (r_data_o !== {exp_lo + 8'd1, exp_lo} || empty_o !== 1'b0) begin
               errors++;
               $display("FAIL wrap_pair r%0d p%0d got %h e=%b want %h", round, i, r_data_o, empty_o,
                        {exp_lo + 8'd1, exp_lo});
            end
            drive(1'b0, 8'h00, 1'b1);
            exp_lo += 8'd2;
         end
      end
   endtask

   task automatic test_simul;
      drive(1'b1, 8'h01, 1'b0);
      drive(1'b1, 8'h02, 1'b0);
      drive(1'b1, 8'h03, 1'b0);
      checks++;
      if (count_o !== 3'd3 || r_data_o !== 16'h0201) begin
         errors++;
         $display("FAIL simul_pre got c=%0d d=%h want c=3 d=0201", count_o, r_data_o);
      end
      drive(1'b1, 8'h04, 1'b1);
      checks++;
      if (count_o !== 3'd2 || r_data_o !== 16'h0403) begin
         errors++;
         $display("FAIL simul_post got c=%0d d=%h want c=2 d=0403", count_o, r_data_o);
      end
      drive(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_reset_mid;
      drive(1'b1, 8'h71, 1'b0);
      drive(1'b1, 8'h72, 1'b0);
      drive(1'b1, 8'h73, 1'b0);
      do_reset(1'b1, 1'b1);
      checks++;
      if (count_o !== 3'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got c=%0d e=%b f=%b want c=0 e=1 f=0", count_o, empty_o, full_o);
      end
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h66, 1'b0);
      checks++;
      if (r_data_o !== 16'h6655 || empty_o !== 1'b0) begin
         errors++;
         $display("FAIL after_reset got d=%h e=%b want d=6655 e=0", r_data_o, empty_o);
      end
   endtask

   task automatic test_random;
      logic w, r;
      logic [DW-1:0] d;
      for (int i = 0; i < 400; i++) begin
         w = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 40);
         d = 8'($urandom);
         drive(w, d, r);
         checks++;
         if (count_o !== 3'(mq.size()) || full_o !== (mq.size() == DEPTH) || empty_o !== (mq.size() < 2)) begin
            errors++;
            $display("FAIL rand_flags i=%0d got c=%0d f=%b e=%b want c=%0d", i, count_o, full_o, empty_o, mq.size());
         end
         if (mq.size() >= 2) begin
            checks++;
            if (r_data_o !== {mq[1], mq[0]}) begin
               errors++;
               $display("FAIL rand_data i=%0d got %h want %h", i, r_data_o, {mq[1], mq[0]});
            end
         end
      end
   endtask

   initial begin
      rst_ni = 1'b0; wr_i = 1'b0; rd_i = 1'b0; w_data_i = '0;
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_simul();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
